// File: rtl/pcihellocore_led_seq_pkg.sv
// Shared definitions for the LED sequencer: register map, modes, FSM states, reset values.
package pcihellocore_led_seq_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_PERIOD  = 3'd1;
    localparam logic [2:0] ADDR_PATTERN = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_CURRENT = 3'd4;

    localparam logic [31:0] DEF_RESET_PATTERN = 32'h0010_1010;
    localparam logic [31:0] DEF_RESET_PERIOD  = 32'd50_000_000;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROT_L  = 2'b10,
        MODE_ROT_R  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_TICK = 2'd2
    } state_e;

    typedef struct packed {
        logic  irq_en;
        mode_e mode;
        logic  enable;
    } ctrl_t;

    // A period of 0 behaves like 1, so the terminal count is never negative.
    function automatic logic [31:0] period_limit(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/pcihellocore_led_seq_timer.sv
// Step prescaler: counts while enabled and pulses tick on the terminal count.
module pcihellocore_led_seq_timer
    import pcihellocore_led_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] r_count;
    logic [31:0] w_limit;

    assign w_limit = period_limit(period);
    assign tick    = enable && !clear && (r_count == w_limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || !enable || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/pcihellocore_led_sequencer.sv
// LED pattern sequencer: slave register file plus a master that pushes frames to an LED PIO.
module pcihellocore_led_sequencer
    import pcihellocore_led_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PATTERN = DEF_RESET_PATTERN,
    parameter logic [31:0] RESET_PERIOD  = DEF_RESET_PERIOD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        irq
);

    state_e      r_state, w_state_next;
    ctrl_t       r_ctrl;
    logic [31:0] r_period, r_pattern, r_frame;
    logic [4:0]  r_step;
    logic        r_phase, r_wrap, r_reload_pending;

    logic        w_wr, w_ctrl_wr, w_period_wr, w_pattern_wr, w_status_wr;
    logic        w_enable_eff, w_start, w_done, w_pat_live, w_reload, w_advance, w_tick;
    logic [31:0] w_reload_value, w_frame_adv;
    logic [4:0]  w_step_adv;
    logic        w_phase_adv, w_wrap_hit, w_wrap_set;

    assign w_wr         = chipselect && !write_n;
    assign w_ctrl_wr    = w_wr && (address == ADDR_CTRL);
    assign w_period_wr  = w_wr && (address == ADDR_PERIOD);
    assign w_pattern_wr = w_wr && (address == ADDR_PATTERN);
    assign w_status_wr  = w_wr && (address == ADDR_STATUS);

    // A same-cycle CTRL write decides enable so that disabling stops WAIT_TICK at once.
    assign w_enable_eff   = w_ctrl_wr ? writedata[0] : r_ctrl.enable;
    assign w_start        = (r_state == ST_IDLE) && w_ctrl_wr && writedata[0] && !r_ctrl.enable;
    assign w_done         = (r_state == ST_ISSUE) && !m_waitrequest;
    assign w_pat_live     = w_pattern_wr && r_ctrl.enable;
    assign w_reload_value = w_pattern_wr ? writedata : r_pattern;
    assign w_reload       = w_start
                         || (w_done && w_enable_eff && (r_reload_pending || w_pat_live))
                         || ((r_state == ST_WAIT_TICK) && w_enable_eff && w_pat_live);
    assign w_advance      = (r_state == ST_WAIT_TICK) && w_enable_eff && !w_pat_live
                         && w_tick && (r_ctrl.mode != MODE_STATIC);
    assign w_wrap_set     = w_advance && w_wrap_hit;

    pcihellocore_led_seq_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_period_wr),
        .enable  (r_state == ST_WAIT_TICK),
        .period  (r_period),
        .tick    (w_tick)
    );

    always_comb begin
        w_frame_adv = r_frame;
        w_step_adv  = r_step;
        w_phase_adv = r_phase;
        w_wrap_hit  = 1'b0;
        case (r_ctrl.mode)
            MODE_BLINK: begin
                w_phase_adv = !r_phase;
                w_frame_adv = r_phase ? 32'd0 : r_pattern;
                w_wrap_hit  = !r_phase;
            end
            MODE_ROT_L: begin
                w_frame_adv = {r_frame[30:0], r_frame[31]};
                w_step_adv  = r_step + 5'd1;
                w_wrap_hit  = (r_step == 5'd31);
            end
            MODE_ROT_R: begin
                w_frame_adv = {r_frame[0], r_frame[31:1]};
                w_step_adv  = r_step + 5'd1;
                w_wrap_hit  = (r_step == 5'd31);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_done) begin
                    if (!w_enable_eff)  w_state_next = ST_IDLE;
                    else if (w_reload)  w_state_next = ST_ISSUE;
                    else                w_state_next = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (!w_enable_eff)              w_state_next = ST_IDLE;
                else if (w_reload || w_advance) w_state_next = ST_ISSUE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_address   = 2'b00;
        m_write     = (r_state == ST_ISSUE);
        m_writedata = r_frame;
        irq         = r_wrap && r_ctrl.irq_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl           <= '0;
            r_period         <= RESET_PERIOD;
            r_pattern        <= RESET_PATTERN;
            r_frame          <= RESET_PATTERN;
            r_step           <= '0;
            r_phase          <= 1'b1;
            r_wrap           <= 1'b0;
            r_reload_pending <= 1'b0;
        end else begin
            if (w_ctrl_wr)    r_ctrl    <= ctrl_t'(writedata[3:0]);
            if (w_period_wr)  r_period  <= writedata;
            if (w_pattern_wr) r_pattern <= writedata;
            // A wrap event wins over a same-cycle W1C.
            r_wrap <= w_wrap_set || (r_wrap && !(w_status_wr && writedata[1]));
            if (w_reload) begin
                r_frame <= w_reload_value;
                r_step  <= '0;
                r_phase <= 1'b1;
            end else if (w_advance) begin
                r_frame <= w_frame_adv;
                r_step  <= w_step_adv;
                r_phase <= w_phase_adv;
            end
            if ((r_state == ST_ISSUE) && m_waitrequest && w_pat_live) begin
                r_reload_pending <= 1'b1;
            end else if (w_done || (r_state == ST_IDLE)) begin
                r_reload_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:    readdata = {28'd0, r_ctrl};
            ADDR_PERIOD:  readdata = r_period;
            ADDR_PATTERN: readdata = r_pattern;
            ADDR_STATUS:  readdata = {30'd0, r_wrap, m_write};
            ADDR_CURRENT: readdata = r_frame;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pcihellocore_led_sequencer.sv
// Directed bench: stimulus queues expected LED writes, a monitor checks each accepted transfer.
module tb_pcihellocore_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        irq;

    pcihellocore_led_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .irq           (irq)
    );

    typedef struct {
        logic [31:0] data;
        int          gap;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   n_xfer   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int g, input logic i);
        exp_t e;
        e.data = d;
        e.gap  = g;
        e.irq  = i;
        sb_q.push_back(e);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(nm, readdata, exp);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk(nm, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Monitor: every accepted master transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && m_write && !m_waitrequest) begin
            n_xfer++;
            $display("xfer %0d @cyc %0d: data=%h irq=%b", n_xfer, cyc, m_writedata, irq);
            if (sb_q.size() == 0) begin
                chk("unexpected_write", m_writedata, 32'hxxxx_xxxx);
            end else begin
                mon_e = sb_q.pop_front();
                chk("m_writedata", m_writedata, mon_e.data);
                chk("irq_at_write", {31'd0, irq}, {31'd0, mon_e.irq});
                if (mon_e.gap != 0) chk("write_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
                chk("m_address", {30'd0, m_address}, 32'd0);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        reset_n       = 1'b0;
        address       = '0;
        chipselect    = 1'b0;
        write_n       = 1'b1;
        writedata     = '0;
        m_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_write", {31'd0, m_write}, 32'd0);
        chk("rst_m_writedata", m_writedata, 32'h0010_1010);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        read_chk("rst_ctrl", 3'd0, 32'd0);
        read_chk("rst_period", 3'd1, 32'd50_000_000);
        read_chk("rst_pattern", 3'd2, 32'h0010_1010);
        read_chk("rst_status", 3'd3, 32'd0);
        read_chk("rst_current", 3'd4, 32'h0010_1010);
        read_chk("rd_unmapped", 3'd7, 32'd0);

        // Rotate-left, one write every PERIOD+1 cycles, no wrap.
        @(posedge clk); #1;
        bus_write(3'd2, 32'h1);
        bus_write(3'd1, 32'd4);
        push(32'h1, 0, 1'b0);
        push(32'h2, 5, 1'b0);
        push(32'h4, 5, 1'b0);
        push(32'h8, 5, 1'b0);
        push(32'h10, 5, 1'b0);
        bus_write(3'd0, 32'h5);
        wait_drain("rotl_drain");
        bus_write(3'd0, 32'h0);
        read_chk("rotl_status", 3'd3, 32'd0);
        chk("rotl_irq", {31'd0, irq}, 32'd0);

        // Blink with irq enabled: wrap on the return to PATTERN, then W1C.
        bus_write(3'd2, 32'hF0);
        bus_write(3'd1, 32'd2);
        push(32'hF0, 0, 1'b0);
        push(32'h00, 3, 1'b0);
        push(32'hF0, 3, 1'b1);
        bus_write(3'd0, 32'hB);
        wait_drain("blink_drain");
        bus_write(3'd0, 32'h8);
        chk("blink_irq_set", {31'd0, irq}, 32'd1);
        read_chk("blink_status", 3'd3, 32'h2);
        bus_write(3'd3, 32'h2);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        read_chk("w1c_status", 3'd3, 32'd0);

        // Stalled ISSUE held for 4 cycles; CTRL=0 lands mid-stall.
        bus_write(3'd2, 32'h5A);
        bus_write(3'd1, 32'd4);
        m_waitrequest = 1'b1;
        push(32'h5A, 0, 1'b0);
        bus_write(3'd0, 32'h5);
        for (int k = 0; k < 4; k++) begin
            chipselect = 1'b0;
            write_n    = 1'b1;
            if (k == 3) m_waitrequest = 1'b0;
            address = 3'd3;
            #1;
            chk("stall_m_write", {31'd0, m_write}, 32'd1);
            chk("stall_data", m_writedata, 32'h5A);
            chk("stall_busy", {31'd0, readdata[0]}, 32'd1);
            if (k == 1) begin
                address    = 3'd0;
                writedata  = 32'h0;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            @(posedge clk); #1;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        wait_drain("stall_drain");
        repeat (10) begin
            chk("disabled_no_write", {31'd0, m_write}, 32'd0);
            @(posedge clk); #1;
        end
        read_chk("disabled_status", 3'd3, 32'd0);

        // Rotate-right: PATTERN write on the terminal-count cycle wins over the step.
        bus_write(3'd2, 32'h3);
        bus_write(3'd1, 32'd3);
        push(32'h3, 0, 1'b0);
        push(32'hABCD, 4, 1'b0);
        push(32'h8000_55E6, 4, 1'b0);
        bus_write(3'd0, 32'h7);
        repeat (3) @(posedge clk);
        #1;
        bus_write(3'd2, 32'hABCD);
        wait_drain("rotr_drain");
        bus_write(3'd0, 32'h0);
        read_chk("rotr_current", 3'd4, 32'h8000_55E6);

        // Asynchronous reset in the middle of a stalled ISSUE.
        m_waitrequest = 1'b1;
        bus_write(3'd2, 32'h77);
        bus_write(3'd0, 32'h5);
        chk("pre_rst_m_write", {31'd0, m_write}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_m_write", {31'd0, m_write}, 32'd0);
        chk("async_rst_data", m_writedata, 32'h0010_1010);
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        m_waitrequest = 1'b0;
        reset_n = 1'b1;
        read_chk("post_rst_current", 3'd4, 32'h0010_1010);
        read_chk("post_rst_period", 3'd1, 32'd50_000_000);
        read_chk("post_rst_ctrl", 3'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("final_m_write", {31'd0, m_write}, 32'd0);
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcihellocore_led_sequencer.md
PCIHELLOCORE_LED_SEQUENCER -- requirements
Module: pcihellocore_led_sequencer

Interface
REQ-001 The block SHALL have the parameter RESET_PATTERN, default 32'h0010_1010, which is the reset frame and pattern value.
REQ-002 The block SHALL have the parameter RESET_PERIOD, default 32'd50_000_000, which is the reset step period in clk cycles.
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  slave word address
- chipselect  input  1  slave select
- write_n  input  1  slave write strobe, active low
- writedata  input  32  slave write data
- readdata  output  32  slave read data, zero-wait, combinational
- m_address  output  2  master address, constant 0 (LED PIO data register)
- m_write  output  1  master write request
- m_writedata  output  32  master write data, i.e. the LED frame
- m_waitrequest  input  1  master stall from the LED PIO
- irq  output  1  wrap interrupt, level

Function
REQ-004 The slave register map SHALL be:
- 0 CTRL: [0] enable, [2:1] mode, [3] irq_en
- 1 PERIOD
- 2 PATTERN
- 3 STATUS: [0] busy (RO), [1] wrap (W1C)
- 4 CURRENT (RO, current frame)
- other addresses read 0 and ignore writes.
REQ-005 Slave writes SHALL take effect when chipselect && !write_n, on that clk edge; readdata SHALL be combinational from address.
REQ-006 Mode encoding SHALL be: 00 static, 01 blink, 10 rotate-left, 11 rotate-right.
REQ-007 The FSM SHALL have states IDLE, ISSUE and WAIT_TICK.
REQ-008 IDLE->ISSUE SHALL occur on the enable 0->1 write; frame<=PATTERN, step<=0, blink phase<=1.
REQ-009 In ISSUE, m_write=1 and m_writedata=frame, both held stable while m_waitrequest=1; on the first cycle with m_waitrequest=0 the FSM SHALL go to WAIT_TICK with counter=0, or to IDLE if enable=0.
REQ-010 In WAIT_TICK the counter SHALL increment each cycle; at counter==max(PERIOD,1)-1 it SHALL compute the next frame and go to ISSUE.
REQ-011 The next frame SHALL be:
- static: unchanged, and no further ISSUE until the frame is reloaded
- blink: phase toggles, frame = phase ? PATTERN : 0
- rotate-left/right: rotate by 1 bit.
REQ-012 Wrap SHALL be set when the rotate step counter (5 bits) goes from 31 to 0, or when the blink phase returns to 1.
REQ-013 irq SHALL equal STATUS.wrap && CTRL.irq_en.
REQ-014 A PATTERN write while enabled SHALL reload frame<=PATTERN, step<=0, phase<=1; if in WAIT_TICK the FSM SHALL go to ISSUE next cycle; if in ISSUE the reload SHALL apply after the current transfer completes, followed by one more ISSUE.
REQ-015 A PATTERN write SHALL take priority over a same-cycle terminal count; the same-cycle step is discarded.
REQ-016 A PERIOD write SHALL clear the counter.
REQ-017 A PERIOD value of 0 SHALL be treated as 1.
REQ-018 Writing enable=0 SHALL send WAIT_TICK to IDLE immediately; ISSUE SHALL complete its transfer first; m_write SHALL never drop while m_waitrequest=1.
REQ-019 STATUS.busy SHALL equal m_write.
REQ-020 A wrap set and a W1C clear in the same cycle SHALL leave wrap=1.
REQ-021 The counter SHALL be 32-bit unsigned with no overflow path, since it is bounded by PERIOD.

Reset
REQ-022 While reset_n=0, asynchronously, the block SHALL hold: FSM=IDLE, CTRL=0, PERIOD=RESET_PERIOD, PATTERN=frame=RESET_PATTERN, counter=0, step=0, phase=1, wrap=0, m_write=0, m_writedata=RESET_PATTERN, irq=0.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer with no completion required.

Structure
REQ-024 The package pcihellocore_led_seq_pkg SHALL hold the register offsets, the mode encodings, the FSM state enum and the reset constants.
REQ-025 The prescaler SHALL be one sub-module, pcihellocore_led_seq_timer (inputs: clear, enable, period; output: tick).

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- PATTERN=1, PERIOD=4, CTRL=0x5 (rotate-left, enable), m_waitrequest=0 -> m_writedata 1,2,4,8..., one write every 5 cycles; wrap and irq=0 with irq_en=0.
- PATTERN=0xF0, PERIOD=2, blink mode, CTRL=0xB -> writes 0xF0, 0, 0xF0; wrap=1 and irq=1 at the second 0xF0; W1C STATUS=2 -> irq=0.
- m_waitrequest=1 for 3 cycles during ISSUE -> m_write and m_writedata stable for 4 cycles; busy=1 throughout.
- CTRL=0 written during a stalled ISSUE -> transfer completes, then IDLE, no further m_write.
- PATTERN write on the terminal-count cycle in rotate-right -> next write carries the new PATTERN unrotated.
- reset_n pulsed low mid-ISSUE -> m_write=0 at once; readback CURRENT=0x00101010, PERIOD=50000000.
